// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, widths
// and the default reset PC.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one instruction at a time from instruction
// memory, holds it until the control FSM retires it, then fetches the next one.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  input  logic            advance,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instret,
  output logic            fault
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_d, instr_d, instret_d, imem_addr_d;
  logic            imem_req_d, instr_valid_d, fault_d;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  // Retirement target: sequential pc+4 wraps naturally at 2^32.
  assign next_pc    = redirect ? redirect_pc : (pc + XLEN'(INSTR_BYTES));
  assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instret     <= '0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      instr       <= instr_d;
      instr_valid <= instr_valid_d;
      imem_req    <= imem_req_d;
      imem_addr   <= imem_addr_d;
      instret     <= instret_d;
      fault       <= fault_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc;
    instr_d       = instr;
    instr_valid_d = instr_valid;
    imem_req_d    = imem_req;
    imem_addr_d   = imem_addr;
    instret_d     = instret;
    fault_d       = fault;

    unique case (state_q)
      IDLE: begin
        if (fetch_en) begin
          state_d     = REQ;
          imem_req_d  = 1'b1;
          imem_addr_d = pc;
        end
      end
      REQ: begin
        imem_req_d  = 1'b1;
        imem_addr_d = pc;
        if (imem_ack) begin
          state_d       = HOLD;
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
        end
      end
      HOLD: begin
        if (advance) begin
          instr_valid_d = 1'b0;
          if (misaligned) begin
            // Misaligned target: stop without retiring; only reset recovers.
            state_d    = FAULT;
            fault_d    = 1'b1;
            imem_req_d = 1'b0;
          end else begin
            state_d     = REQ;
            pc_d        = next_pc;
            imem_addr_d = next_pc;
            imem_req_d  = 1'b1;
            instret_d   = instret + XLEN'(1);
          end
        end
      end
      FAULT: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
        fault_d       = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, fetch_en, advance, redirect, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, instr_valid, fault;
  logic [31:0] imem_addr, instr, pc, instret;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] S_IDLE = 32'd0, S_REQ = 32'd1, S_HOLD = 32'd2, S_FAULT = 32'd3;
  localparam logic [31:0] W0 = 32'h0020_81B3, W1 = 32'h1111_0013, W2 = 32'h2222_0013;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .advance(advance),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .instret(instret), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] st, input logic req,
                           input logic [31:0] addr, input logic [31:0] ins, input logic vld,
                           input logic [31:0] p, input logic [31:0] ret, input logic flt);
    check({tag, ".state"}, 32'(dut.state_q), st);
    check({tag, ".imem_req"}, 32'(imem_req), 32'(req));
    check({tag, ".imem_addr"}, imem_addr, addr);
    check({tag, ".instr"}, instr, ins);
    check({tag, ".instr_valid"}, 32'(instr_valid), 32'(vld));
    check({tag, ".pc"}, pc, p);
    check({tag, ".instret"}, instret, ret);
    check({tag, ".fault"}, 32'(fault), 32'(flt));
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; advance = 1'b0; redirect = 1'b0;
    imem_ack = 1'b0; redirect_pc = '0; imem_rdata = '0;
    step(); step();
    check_all("reset", S_IDLE, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    rst = 1'b0;

    // Zero-wait fetch from reset PC.
    fetch_en = 1'b1; step(); fetch_en = 1'b0;
    check_all("req0", S_REQ, 1, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    imem_ack = 1'b1; imem_rdata = W0; step(); imem_ack = 1'b0;
    check_all("hold0", S_HOLD, 0, 32'h0, W0, 1, 32'h0, 32'h0, 0);

    // Spurious ack in HOLD is ignored.
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; step(); imem_ack = 1'b0;
    check_all("spur_ack", S_HOLD, 0, 32'h0, W0, 1, 32'h0, 32'h0, 0);

    // Sequential advance.
    advance = 1'b1; step(); advance = 1'b0;
    check_all("adv_seq", S_REQ, 1, 32'h4, W0, 0, 32'h4, 32'h1, 0);

    // Advance in REQ ignored, then 5 wait cycles.
    advance = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200; step();
    advance = 1'b0; redirect = 1'b0;
    check_all("adv_in_req", S_REQ, 1, 32'h4, W0, 0, 32'h4, 32'h1, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_all("wait", S_REQ, 1, 32'h4, W0, 0, 32'h4, 32'h1, 0);
    end
    imem_ack = 1'b1; imem_rdata = W1; step(); imem_ack = 1'b0;
    check_all("hold1", S_HOLD, 0, 32'h4, W1, 1, 32'h4, 32'h1, 0);

    // Redirect without advance ignored.
    redirect = 1'b1; redirect_pc = 32'h0000_0300; step(); redirect = 1'b0;
    check_all("redir_noadv", S_HOLD, 0, 32'h4, W1, 1, 32'h4, 32'h1, 0);

    // Aligned redirect.
    advance = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0100; step();
    advance = 1'b0; redirect = 1'b0;
    check_all("redir", S_REQ, 1, 32'h100, W1, 0, 32'h100, 32'h2, 0);
    imem_ack = 1'b1; imem_rdata = W2; step(); imem_ack = 1'b0;
    check_all("hold2", S_HOLD, 0, 32'h100, W2, 1, 32'h100, 32'h2, 0);

    // Jump to top of address space, then pc+4 wraps to 0.
    advance = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; step();
    advance = 1'b0; redirect = 1'b0;
    check_all("redir_top", S_REQ, 1, 32'hFFFF_FFFC, W2, 0, 32'hFFFF_FFFC, 32'h3, 0);
    imem_ack = 1'b1; imem_rdata = W0; step(); imem_ack = 1'b0;
    check_all("hold_top", S_HOLD, 0, 32'hFFFF_FFFC, W0, 1, 32'hFFFF_FFFC, 32'h3, 0);
    advance = 1'b1; step(); advance = 1'b0;
    check_all("wrap", S_REQ, 1, 32'h0, W0, 0, 32'h0, 32'h4, 0);
    imem_ack = 1'b1; imem_rdata = W1; step(); imem_ack = 1'b0;
    check_all("hold_wrap", S_HOLD, 0, 32'h0, W1, 1, 32'h0, 32'h4, 0);

    // Misaligned redirect faults and stays faulted.
    advance = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0102; step();
    advance = 1'b0; redirect = 1'b0;
    check_all("fault", S_FAULT, 0, 32'h0, W1, 0, 32'h0, 32'h4, 1);
    fetch_en = 1'b1; imem_ack = 1'b1; advance = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("fault_hold", S_FAULT, 0, 32'h0, W1, 0, 32'h0, 32'h4, 1);
    end
    fetch_en = 1'b0; imem_ack = 1'b0; advance = 1'b0;

    // Reset clears fault.
    rst = 1'b1; step(); rst = 1'b0;
    check_all("fault_rst", S_IDLE, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);

    // Reset during REQ with same-cycle ack, then a late ack.
    fetch_en = 1'b1; step(); fetch_en = 1'b0;
    check_all("req_r", S_REQ, 1, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = W2; step(); rst = 1'b0;
    check_all("rst_ack", S_IDLE, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    step(); imem_ack = 1'b0;
    check_all("late_ack", S_IDLE, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
